// File: rtl/router_pkg.sv
// Router control shared definitions.
// State encoding, port count and timeout length.
package router_pkg;

  localparam int PORTS   = 3;
  localparam int ADDR_W  = 2;
  localparam int TIMEOUT = 30;
  localparam int CNT_W   = 5;

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    WAIT_TILL_EMPTY,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    CHECK_PARITY
  } state_e;

  function automatic logic [PORTS-1:0] port_sel(
    input logic [ADDR_W-1:0] a
  );
    logic [PORTS-1:0] one;
    one = {{(PORTS-1){1'b0}}, 1'b1};
    return one << a;
  endfunction

endpackage

// File: rtl/router_ctrl_if.sv
// Source/FIFO-side bundle of the router controller.
// master = environment, slave = controller.
interface router_ctrl_if;
  import router_pkg::*;

  logic             pkt_valid;
  logic [7:0]       data_in;
  logic [PORTS-1:0] fifo_full;
  logic [PORTS-1:0] fifo_empty;
  logic [PORTS-1:0] read_enb;
  logic [PORTS-1:0] write_enb;
  logic [7:0]       fifo_din;
  logic             lfd_state;
  logic             busy;
  logic [PORTS-1:0] vld_out;
  logic [PORTS-1:0] soft_reset;
  logic             err;
  logic             detect_add;

  modport master (
    output pkt_valid, data_in, fifo_full,
    output fifo_empty, read_enb,
    input  write_enb, fifo_din, lfd_state,
    input  busy, vld_out, soft_reset,
    input  err, detect_add
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full,
    input  fifo_empty, read_enb,
    output write_enb, fifo_din, lfd_state,
    output busy, vld_out, soft_reset,
    output err, detect_add
  );

endinterface

// File: rtl/router_timeout.sv
// Per-port idle watchdog: pulses soft_reset on
// the 30th consecutive unread cycle of valid data.
module router_timeout
  import router_pkg::*;
(
  input  logic clock,
  input  logic resetn,
  input  logic vld,
  input  logic read,
  output logic soft_reset
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             idle;
  logic             hit;

  always_comb begin
    idle = vld & ~read;
    hit  = idle && (cnt_q == CNT_W'(TIMEOUT - 1));
    if (!idle || hit) cnt_d = '0;
    else              cnt_d = cnt_q + 1'b1;
  end

  assign soft_reset = hit & resetn;

  always_ff @(posedge clock) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/router_ctrl.sv
// Router packet controller: header decode, FIFO
// write steering, parity check, per-port timeout.
module router_ctrl
  import router_pkg::*;
(
  input logic          clock,
  input logic          resetn,
  router_ctrl_if.slave bus
);

  state_e              state_q, state_d;
  logic [7:0]          hdr_q, hdr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          parity_q, parity_d;
  logic                err_q, err_d;

  logic [PORTS-1:0]    vld_out;
  logic [PORTS-1:0]    soft_rst;
  logic [ADDR_W-1:0]   hdr_addr;
  logic                sr;
  logic                full;
  logic [PORTS-1:0]    write_enb;
  logic [7:0]          fifo_din;
  logic                lfd_state;
  logic                busy;
  logic                detect_add;

  assign vld_out  = ~bus.fifo_empty;
  assign hdr_addr = bus.data_in[ADDR_W-1:0];
  assign sr       = soft_rst[addr_q];
  assign full     = bus.fifo_full[addr_q];

  for (genvar i = 0; i < PORTS; i++) begin : g_to
    router_timeout u_to (
      .clock      (clock),
      .resetn     (resetn),
      .vld        (vld_out[i]),
      .read       (bus.read_enb[i]),
      .soft_reset (soft_rst[i])
    );
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= DECODE_ADDRESS;
      hdr_q    <= '0;
      addr_q   <= '0;
      parity_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hdr_q    <= hdr_d;
      addr_q   <= addr_d;
      parity_q <= parity_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hdr_d    = hdr_q;
    addr_d   = addr_q;
    parity_d = parity_q;
    err_d    = err_q;
    unique case (state_q)
      DECODE_ADDRESS: begin
        if (bus.pkt_valid && hdr_addr != 2'b11) begin
          hdr_d   = bus.data_in;
          addr_d  = hdr_addr;
          state_d = bus.fifo_empty[hdr_addr] ?
                    LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      WAIT_TILL_EMPTY: begin
        if (sr)
          state_d = DECODE_ADDRESS;
        else if (bus.fifo_empty[addr_q])
          state_d = LOAD_FIRST_DATA;
      end
      LOAD_FIRST_DATA: begin
        if (sr) begin
          state_d = DECODE_ADDRESS;
        end else begin
          parity_d = hdr_q;
          err_d    = 1'b0;
          state_d  = LOAD_DATA;
        end
      end
      LOAD_DATA: begin
        if (sr) begin
          state_d = DECODE_ADDRESS;
        end else if (full) begin
          state_d = FIFO_FULL_STATE;
        end else if (bus.pkt_valid) begin
          parity_d = parity_q ^ bus.data_in;
        end else begin
          // pkt_valid low marks the parity byte
          err_d   = (bus.data_in != parity_q);
          state_d = CHECK_PARITY;
        end
      end
      FIFO_FULL_STATE: begin
        if (sr)
          state_d = DECODE_ADDRESS;
        else if (!full)
          state_d = LOAD_DATA;
      end
      CHECK_PARITY: state_d = DECODE_ADDRESS;
      default:      state_d = DECODE_ADDRESS;
    endcase
  end

  always_comb begin
    write_enb  = '0;
    fifo_din   = bus.data_in;
    lfd_state  = 1'b0;
    busy       = 1'b1;
    detect_add = 1'b0;
    unique case (state_q)
      DECODE_ADDRESS: begin
        busy       = 1'b0;
        detect_add = 1'b1;
      end
      LOAD_FIRST_DATA: begin
        lfd_state = 1'b1;
        fifo_din  = hdr_q;
        if (!sr) write_enb = port_sel(addr_q);
      end
      LOAD_DATA: begin
        busy = full;
        if (!full && !sr) write_enb = port_sel(addr_q);
      end
      default: busy = 1'b1;
    endcase
    if (!resetn) begin
      write_enb = '0;
      lfd_state = 1'b0;
    end
  end

  assign bus.write_enb  = write_enb;
  assign bus.fifo_din   = fifo_din;
  assign bus.lfd_state  = lfd_state;
  assign bus.busy       = busy;
  assign bus.detect_add = detect_add;
  assign bus.vld_out    = vld_out;
  assign bus.soft_reset = soft_rst;
  assign bus.err        = err_q;

endmodule
